// File: rtl/seg_scan_driver.sv
// Scans a double-buffered 6-digit common-anode 7-segment display; outputs lag the scan state by 1 cycle.
// No backpressure: loads are always accepted and reach the display only at frame boundaries. Blink: SEG_BLINK_EN.
module seg_scan_driver #(
    parameter int SCAN_DIV    = 50000,
    parameter int GUARD       = 16,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [23:0] data_i,
    input  logic [5:0]  dp_en_i,
    input  logic [5:0]  blank_i,
    input  logic [5:0]  blink_i,
    output logic [5:0]  sel_o,
    output logic [7:0]  seg_o,
    output logic        frame_done_o
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic [23:0]   sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [5:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [5:0]    sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q;
    logic          tick, boundary;
    logic [5:0]    hide;
    logic          lit;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == 3'd5);

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        idx_d       = idx_q;
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pend_d      = pend_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        if (load_i) begin
            sh_data_d  = data_i;
            sh_dp_d    = dp_en_i;
            sh_blank_d = blank_i;
            pend_d     = 1'b1;
        end
        // sh_*_d already holds the inputs when a load lands on the boundary
        if (boundary) begin
            pend_d = 1'b0;
            if (pend_q || load_i) begin
                act_data_d  = sh_data_d;
                act_dp_d    = sh_dp_d;
                act_blank_d = sh_blank_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            pend_q      <= 1'b0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= 6'h3F;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= 6'h3F;
            sel_q       <= 6'h3F;
            seg_q       <= 8'hFF;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
            fd_q        <= boundary;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [5:0]    sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        sh_blink_d  = load_i ? blink_i : sh_blink_q;
        act_blink_d = (boundary && (pend_q || load_i)) ? sh_blink_d : act_blink_q;
        bcnt_d      = bcnt_q;
        phase_d     = phase_q;
        if (tick) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_blink_q  <= '0;
            act_blink_q <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b0;
        end else begin
            sh_blink_q  <= sh_blink_d;
            act_blink_q <= act_blink_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
        end
    end

    assign hide = act_blank_q | (act_blink_q & {6{phase_q}});
`else
    logic unused_blink;
    assign unused_blink = ^blink_i;
    assign hide = act_blank_q;
`endif

    assign nib = act_data_q[{idx_q, 2'b00} +: 4];
    assign lit = (cnt_q >= GUARD_C) && !hide[idx_q];

    always_comb begin
        sel_d = 6'h3F;
        seg_d = 8'hFF;
        if (lit) begin
            sel_d = ~(6'b000001 << idx_q);
            seg_d = {~act_dp_q[idx_q], hex7(nib)};
        end
    end

    assign sel_o        = sel_q;
    assign seg_o        = seg_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: decode table, hand-written frame sequences and randomized loads/resets
// checked every cycle against a frame-position model (SCAN_DIV=8, GUARD=2, BLINK_TICKS=2).
module tb_seg_scan_driver;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FR = 6 * SD;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [23:0] data;
    logic [5:0]  dp_en, blank, blink;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        fd;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_TICKS(2)) dut (
        .clk_i(clk), .rst_i(rst), .load_i(load), .data_i(data), .dp_en_i(dp_en),
        .blank_i(blank), .blink_i(blink), .sel_o(sel), .seg_o(seg), .frame_done_o(fd)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // model: pos is the frame position (0..47) currently held by the DUT's scan state
    int          pos;
    logic [23:0] m_act_data, m_sh_data;
    logic [5:0]  m_act_dp, m_sh_dp, m_act_blank, m_sh_blank, m_act_blink, m_sh_blink;
    bit          m_pend, m_phase;
    int          m_bticks;
    logic [5:0]  e_sel;
    logic [7:0]  e_seg;
    logic        e_fd;

    logic [7:0]  cap [6];
    bit          saw_f9;
    int          fd_count, lit_count;

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [7:0] exp_seg;
    } vec_t;
    vec_t vecs [19];

    task automatic model_edge();
        int d, o;
        logic [5:0] hide;
        if (rst) begin
            e_sel = 6'h3F; e_seg = 8'hFF; e_fd = 1'b0; pos = 0;
            m_act_data = '0; m_sh_data = '0; m_act_dp = '0; m_sh_dp = '0;
            m_act_blank = 6'h3F; m_sh_blank = 6'h3F; m_act_blink = '0; m_sh_blink = '0;
            m_pend = 0; m_phase = 0; m_bticks = 0;
        end else begin
            d = pos / SD;
            o = pos % SD;
            hide = m_act_blank;
`ifdef SEG_BLINK_EN
            if (m_phase) hide = hide | m_act_blink;
`endif
            e_sel = 6'h3F;
            e_seg = 8'hFF;
            if (o >= GD && !hide[d]) begin
                e_sel[d] = 1'b0;
                e_seg = hex_tab[m_act_data[4*d +: 4]];
                if (m_act_dp[d]) e_seg[7] = 1'b0;
            end
            e_fd = (pos == FR - 1);
            if (load) begin
                m_sh_data = data; m_sh_dp = dp_en; m_sh_blank = blank; m_sh_blink = blink;
                m_pend = 1;
            end
            if (pos == FR - 1) begin
                if (m_pend) begin
                    m_act_data = m_sh_data; m_act_dp = m_sh_dp;
                    m_act_blank = m_sh_blank; m_act_blink = m_sh_blink;
                end
                m_pend = 0;
            end
            if (o == SD - 1) begin
                m_bticks++;
                if (m_bticks == 2) begin
                    m_bticks = 0;
                    m_phase = !m_phase;
                end
            end
            pos = (pos + 1) % FR;
        end
    endtask

    task automatic check_out();
        tests_run++;
        if (sel !== e_sel || seg !== e_seg || fd !== e_fd) begin
            tests_failed++;
            $display("FAIL cycle_out pos=%0d got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                     pos, sel, seg, fd, e_sel, e_seg, e_fd);
        end
    endtask

    task automatic observe();
        if (fd === 1'b1) fd_count++;
        if (sel !== 6'h3F) lit_count++;
        if ($countones(~sel) == 1) begin
            for (int k = 0; k < 6; k++)
                if (sel[k] == 1'b0) cap[k] = seg;
            if (seg == 8'hF9) saw_f9 = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
        observe();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
        load = 1'b1; data = d; dp_en = dp; blank = bl;
        cyc();
        load = 1'b0;
    endtask

    task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cmpint(input string nm, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clear_cap();
        for (int k = 0; k < 6; k++) cap[k] = 8'hFF;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = '{nib: 4'(i), dp: 1'b0, exp_seg: 8'h00};
        vecs[0].exp_seg  = 8'hC0; vecs[1].exp_seg  = 8'hF9; vecs[2].exp_seg  = 8'hA4; vecs[3].exp_seg  = 8'hB0;
        vecs[4].exp_seg  = 8'h99; vecs[5].exp_seg  = 8'h92; vecs[6].exp_seg  = 8'h82; vecs[7].exp_seg  = 8'hF8;
        vecs[8].exp_seg  = 8'h80; vecs[9].exp_seg  = 8'h90; vecs[10].exp_seg = 8'h88; vecs[11].exp_seg = 8'h83;
        vecs[12].exp_seg = 8'hC6; vecs[13].exp_seg = 8'hA1; vecs[14].exp_seg = 8'h86; vecs[15].exp_seg = 8'h8E;
        vecs[16] = '{nib: 4'h0, dp: 1'b1, exp_seg: 8'h40};
        vecs[17] = '{nib: 4'h8, dp: 1'b1, exp_seg: 8'h00};
        vecs[18] = '{nib: 4'hF, dp: 1'b1, exp_seg: 8'h0E};

        rst = 1'b1; load = 1'b0; data = '0; dp_en = '0; blank = '0; blink = '0;
        clear_cap(); saw_f9 = 0;
        run(2);
        rst = 1'b0;

        // dark after reset, frame_done every 48 cycles
        fd_count = 0; lit_count = 0;
        run(2 * FR);
        cmpint("fd_pulses_2frames", fd_count, 2);
        cmpint("dark_after_reset", lit_count, 0);

        // mid-frame load stays invisible until the boundary
        run(20);
        do_load(24'h543210, 6'h00, 6'h00);
        lit_count = 0;
        run(FR - 21);
        cmpint("dark_until_boundary", lit_count, 0);
        clear_cap();
        run(FR);
        cmp8("d0_543210", cap[0], 8'hC0);
        cmp8("d1_543210", cap[1], 8'hF9);
        cmp8("d2_543210", cap[2], 8'hA4);
        cmp8("d3_543210", cap[3], 8'hB0);
        cmp8("d4_543210", cap[4], 8'h99);
        cmp8("d5_543210", cap[5], 8'h92);

        // last of two loads wins
        run(10);
        do_load(24'h111111, 6'h00, 6'h00);
        run(5);
        do_load(24'hFFFFFF, 6'h00, 6'h00);
        run(FR - 17);
        clear_cap(); saw_f9 = 0;
        run(FR);
        for (int k = 0; k < 6; k++) cmp8($sformatf("d%0d_last_load", k), cap[k], 8'h8E);
        cmpint("never_showed_111111", int'(saw_f9), 0);

        // load on the boundary cycle itself
        for (int i = 0; i < FR && pos != FR - 1; i++) cyc();
        do_load(24'hABCDEF, 6'b000001, 6'b100000);
        clear_cap();
        run(FR);
        cmp8("d0_boundary_load", cap[0], 8'h0E);
        cmp8("d1_boundary_load", cap[1], 8'h86);
        cmp8("d2_boundary_load", cap[2], 8'hA1);
        cmp8("d3_boundary_load", cap[3], 8'hC6);
        cmp8("d4_boundary_load", cap[4], 8'h83);
        cmp8("d5_blanked", cap[5], 8'hFF);

        // reset inside digit 3 of a lit frame
        run(3 * SD + 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cmp8("sel_after_rst", {2'b00, sel}, 8'h3F);
        cmp8("seg_after_rst", seg, 8'hFF);
        lit_count = 0;
        run(2 * FR);
        cmpint("dark_after_midframe_rst", lit_count, 0);

        // decode table, digit 0 in the second frame after the load
        for (int v = 0; v < 19; v++) begin
            do_load({6{vecs[v].nib}}, {6{vecs[v].dp}}, 6'h00);
            run(2 * FR);
            cmp8($sformatf("decode_%0h_dp%0d", vecs[v].nib, vecs[v].dp), cap[0], vecs[v].exp_seg);
        end

        // randomized loads, masks and rare resets against the model
        for (int i = 0; i < 4000; i++) begin
            load  = ($urandom_range(0, 15) == 0);
            data  = 24'($urandom);
            dp_en = 6'($urandom);
            blank = 6'($urandom) & 6'($urandom);
            blink = 6'($urandom);
            rst   = ($urandom_range(0, 599) == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
